imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 100, byte address of the first loaded word and of start_pc.
REQ-002 SHALL have parameter MAX_WORDS, default 256, the largest accepted word count.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_data  input  8  loader byte stream.
REQ-006 SHALL have port in_valid  input  1  in_data holds a byte.
REQ-007 SHALL have port in_ready  output  1  the block accepts a byte this cycle.
REQ-008 SHALL have port reload  input  1  single-cycle pulse that requests a new load while in RUN.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  32  instruction-memory byte address.
REQ-011 SHALL have port mem_wdata  output  32  instruction word.
REQ-012 SHALL have port cpu_hold  output  1  holds the core's PC and pipeline frozen.
REQ-013 SHALL have port start_pc  output  32  constant BASE_ADDR, the PC the core restarts from.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a load completes.
REQ-015 SHALL have port err  output  1  sticky error flag for a word count above MAX_WORDS.

Function
REQ-016 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1; nothing else SHALL count as a transfer.
REQ-017 SHALL treat the stream format as a 16-bit big-endian word count N (two bytes), followed by N words of 4 bytes each, most significant byte first.
REQ-018 SHALL implement states HDR_HI, HDR_LO, DATA, WRITE, DONE, RUN and ERROR.
REQ-019 SHALL move HDR_HI to HDR_LO on a transfer, storing it as N[15:8].
REQ-020 SHALL, in HDR_LO on a transfer, store N[7:0] and go to DONE if N==0, to ERROR if N>MAX_WORDS, and to DATA otherwise.
REQ-021 SHALL, in DATA, shift each transferred byte into a 32-bit assembly register and count bytes 0..3; the 4th byte SHALL cause a move to WRITE.
REQ-022 SHALL, in WRITE, hold mem_we=1 for exactly one cycle, with mem_addr=BASE_ADDR+4*k (k = 0-based word index, 32-bit wrap-around arithmetic) and mem_wdata = the assembled word.
REQ-023 SHALL leave WRITE to DONE after word N-1 and to DATA otherwise, with k incremented.
REQ-024 SHALL hold in_ready=1 only in HDR_HI, HDR_LO and DATA; in_ready SHALL be 0 in WRITE, DONE, RUN and ERROR.
REQ-025 SHALL, in DONE, assert done=1 for one cycle and then go to RUN.
REQ-026 SHALL, in RUN, drive cpu_hold=0; in every other state cpu_hold SHALL be 1.
REQ-027 SHALL, on reload in RUN, go to HDR_HI with k, the byte count and the assembly register cleared; reload in any other state SHALL be ignored.
REQ-028 SHALL, in ERROR, set err=1 and stay there until reset, with cpu_hold=1 and mem_we=0.
REQ-029 SHALL keep mem_we=0 outside WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-030 SHALL tolerate in_valid gaps of any length in any accepting state, with the state held and no data lost.

Reset
REQ-031 SHALL, while rst_n=0 (taking effect immediately, asynchronously), set state=HDR_HI, in_ready=1, cpu_hold=1, mem_we=0, done=0, err=0, mem_addr=0, mem_wdata=0, k=0, byte count=0, N=0.
REQ-032 SHALL, on reset mid-load, abandon the partial word with no write issued, and restart at the header on release.

Verification
REQ-033 SHALL be verified with: bytes 00 02, DE AD BE EF, 00 00 00 20 -> writes (100,DEADBEEF) then (104,00000020), done pulse one cycle after the second write, then cpu_hold=0.
REQ-034 SHALL be verified with: header 00 00 -> no mem_we; done one cycle after the second header byte; then RUN.
REQ-035 SHALL be verified with: header 01 01 (257) with MAX_WORDS=256 -> ERROR, err=1, in_ready=0, cpu_hold=1 held for 20 cycles.
REQ-036 SHALL be verified with: one word sent with in_valid toggling every other cycle -> same single write as a gapless stream; in_ready=0 exactly during the WRITE cycle.
REQ-037 SHALL be verified with: rst_n pulsed low after 2 of 4 data bytes, then a full stream 00 01 11 22 33 44 -> no write before reset; afterwards a single write (100,11223344).
REQ-038 SHALL be verified with: reload in RUN, then 00 01 CA FE BA BE -> cpu_hold=1 the next cycle, write (100,CAFEBABE), done, cpu_hold=0; reload pulsed during DATA has no effect.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a byte stream (16-bit word count
// followed by big-endian words) into IMEM writes while holding the core frozen.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd100,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic [31:0] start_pc,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] LP_MAX_WORDS = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_n;
    logic [15:0] r_k;
    logic [1:0]  r_bcnt;
    logic [31:0] r_asm;

    logic        w_xfer;
    logic [15:0] w_n_full;
    logic        w_last;
    logic [31:0] w_word_addr;

    assign w_xfer      = in_valid & in_ready;
    assign w_n_full    = {r_n[15:8], in_data};
    assign w_last      = ((r_k + 16'd1) == r_n);
    assign w_word_addr = BASE_ADDR + {14'd0, r_k, 2'b00};
    assign start_pc    = BASE_ADDR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_HDR_HI: begin
                in_ready = 1'b1;
                if (w_xfer) begin
                    w_next = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                in_ready = 1'b1;
                if (w_xfer) begin
                    if (w_n_full == 16'd0) begin
                        w_next = S_DONE;
                    end else if ({16'd0, w_n_full} > LP_MAX_WORDS) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (w_xfer && (r_bcnt == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = w_word_addr;
                mem_wdata = r_asm;
                w_next    = w_last ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_RUN;
            end
            S_RUN: begin
                cpu_hold = 1'b0;
                if (reload) begin
                    w_next = S_HDR_HI;
                end
            end
            S_ERROR: begin
                err = 1'b1;
            end
            default: begin
                w_next = S_HDR_HI;
            end
        endcase
    end

    // Header, word index and byte assembly; a reload wipes any leftover word state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n    <= 16'd0;
            r_k    <= 16'd0;
            r_bcnt <= 2'd0;
            r_asm  <= 32'd0;
        end else begin
            case (r_state)
                S_HDR_HI: begin
                    if (w_xfer) begin
                        r_n[15:8] <= in_data;
                    end
                end
                S_HDR_LO: begin
                    if (w_xfer) begin
                        r_n[7:0] <= in_data;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_asm  <= {r_asm[23:0], in_data};
                        r_bcnt <= r_bcnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (!w_last) begin
                        r_k <= r_k + 16'd1;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        r_k    <= 16'd0;
                        r_bcnt <= 2'd0;
                        r_asm  <= 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, word writes, gaps, reset, reload, error.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic [31:0] start_pc;
    logic        done;
    logic        err;

    imem_loader #(.BASE_ADDR(32'd100), .MAX_WORDS(256)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .reload   (reload),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .start_pc (start_pc),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int          cyc   = 0;
    int          nwr   = 0;
    int          ndone = 0;
    int          done_cyc = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int          wr_cyc  [16];

    // Write/done monitor, sampled mid-cycle when all DUT outputs are settled.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_we && nwr < 16) begin
            wr_addr[nwr] <= mem_addr;
            wr_data[nwr] <= mem_wdata;
            wr_cyc[nwr]  <= cyc;
            nwr          <= nwr + 1;
        end
        if (done) begin
            ndone    <= ndone + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("xfer_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (cpu_hold && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("run_reached", {31'd0, cpu_hold}, 32'd0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("async_rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int base;
    int bad;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_mem_we",   {31'd0, mem_we},   32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_err",      {31'd0, err},      32'd0);
        check("rst_mem_addr", mem_addr,          32'd0);
        check("rst_mem_wdata", mem_wdata,        32'd0);
        check("start_pc",     start_pc,          32'd100);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word gapless load
        base = nwr;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        wait_run();
        check("t1_nwr",   nwr - base, 32'd2);
        check("t1_addr0", wr_addr[base], 32'd100);
        check("t1_data0", wr_data[base], 32'hDEADBEEF);
        check("t1_addr1", wr_addr[base+1], 32'd104);
        check("t1_data1", wr_data[base+1], 32'h00000020);
        check("t1_ndone", ndone, 32'd1);
        check("t1_done_lat", done_cyc - wr_cyc[base+1], 32'd1);
        check("t1_run_rdy", {31'd0, in_ready}, 32'd0);

        // Empty load
        pulse_reset();
        base = nwr;
        send_byte(8'h00); send_byte(8'h00);
        check("t2_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("t2_done_one", {31'd0, done}, 32'd0);
        check("t2_run", {31'd0, cpu_hold}, 32'd0);
        check("t2_nwr", nwr - base, 32'd0);

        // Word count 257 exceeds MAX_WORDS
        pulse_reset();
        base = nwr;
        send_byte(8'h01); send_byte(8'h01);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) reload = 1'b1;
            if (err !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1 || mem_we !== 1'b0) bad++;
            @(negedge clk);
            reload = 1'b0;
        end
        check("t3_err_hold", bad, 32'd0);
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_nwr", nwr - base, 32'd0);

        // Word count exactly MAX_WORDS is accepted
        pulse_reset();
        send_byte(8'h01); send_byte(8'h00);
        check("t3b_no_err", {31'd0, err}, 32'd0);
        check("t3b_data_rdy", {31'd0, in_ready}, 32'd1);

        // One word with in_valid gaps
        pulse_reset();
        base = nwr;
        send_byte(8'h00); send_byte(8'h01);
        bad = 0;
        send_byte(8'h12); @(negedge clk); if (in_ready !== 1'b1) bad++;
        send_byte(8'h34); @(negedge clk); if (in_ready !== 1'b1) bad++;
        send_byte(8'h56); @(negedge clk); if (in_ready !== 1'b1) bad++;
        send_byte(8'h78);
        check("t4_gap_rdy", bad, 32'd0);
        check("t4_we", {31'd0, mem_we}, 32'd1);
        check("t4_write_rdy", {31'd0, in_ready}, 32'd0);
        wait_run();
        check("t4_nwr", nwr - base, 32'd1);
        check("t4_addr", wr_addr[base], 32'd100);
        check("t4_data", wr_data[base], 32'h12345678);

        // Reset in the middle of a word, then a full stream
        pulse_reset();
        base = nwr;
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        pulse_reset();
        check("t5_no_partial", nwr - base, 32'd0);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_run();
        check("t5_nwr", nwr - base, 32'd1);
        check("t5_addr", wr_addr[base], 32'd100);
        check("t5_data", wr_data[base], 32'h11223344);

        // Reload from RUN; reload during DATA is ignored
        base = nwr;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("t6_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hCA); send_byte(8'hFE);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        send_byte(8'hBA); send_byte(8'hBE);
        check("t6_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("t6_done_pulse", {31'd0, done}, 32'd1);
        wait_run();
        check("t6_nwr", nwr - base, 32'd1);
        check("t6_addr", wr_addr[base], 32'd100);
        check("t6_data", wr_data[base], 32'hCAFEBABE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
